// File: rtl/ifu_fetch_if.sv
// Instruction memory fetch channel.
// One valid/ready request channel (address out) and one response channel with no
// backpressure (instruction data back).
//   master: fetch unit side  - drives req_valid/req_addr, receives req_ready/rsp_*
//   slave : memory side      - receives req_valid/req_addr, drives req_ready/rsp_*
interface ifu_fetch_if #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned INST_LEN = 32
);
    logic                req_valid;
    logic                req_ready;
    logic [XLEN-1:0]     req_addr;
    logic                rsp_valid;
    logic [INST_LEN-1:0] rsp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit feeding the IF/ID pipeline register.
// Owns the PC, keeps at most one fetch outstanding, and presents one instruction per
// slot with hold-under-stall and flush-on-redirect. Invalid slots read as INST_NOP/addr 0.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   imem            fetch channel (master side): request valid/ready/addr, response valid/data
//   redirect_valid  redirect strobe; redirect_pc is the new PC (low two bits ignored)
//   stall           downstream does not consume this cycle
//   o_inst_*        registered output slot {valid, addr, data}
module ifu_fetch #(
    parameter int unsigned         XLEN     = 32,
    parameter int unsigned         INST_LEN = 32,
    parameter logic [INST_LEN-1:0] INST_NOP = 32'h0000_0013,
    parameter logic [XLEN-1:0]     RESET_PC = 32'h8000_0000
) (
    input  logic                clk,
    input  logic                rst,
    ifu_fetch_if.master         imem,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc,
    input  logic                stall,
    output logic                o_inst_valid,
    output logic [XLEN-1:0]     o_inst_addr,
    output logic [INST_LEN-1:0] o_inst_data
);

    typedef enum logic [0:0] {StReq, StWait} state_e;

    state_e              state_q, state_d;
    logic [XLEN-1:0]     pc_q, pc_d;
    logic [XLEN-1:0]     req_addr_q, req_addr_d;
    logic                drop_q, drop_d;
    logic                skid_valid_q, skid_valid_d;
    logic [XLEN-1:0]     skid_addr_q, skid_addr_d;
    logic [INST_LEN-1:0] skid_data_q, skid_data_d;
    logic                out_valid_q, out_valid_d;
    logic [XLEN-1:0]     out_addr_q, out_addr_d;
    logic [INST_LEN-1:0] out_data_q, out_data_d;

    logic req_valid;
    logic handshake;
    logic load_rsp;
    logic consume;
    logic unused_redirect_lsb;

    // Only rst reaches the request combinationally, so nothing is issued during reset.
    assign req_valid     = (state_q == StReq) && !skid_valid_q && !rst;
    assign imem.req_valid = req_valid;
    assign imem.req_addr  = pc_q;

    assign handshake = req_valid && imem.req_ready;
    // A response landing in a redirect cycle is stale by definition.
    assign load_rsp  = (state_q == StWait) && imem.rsp_valid && !drop_q && !redirect_valid;
    assign consume   = out_valid_q && !stall;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    assign o_inst_valid = out_valid_q;
    assign o_inst_addr  = out_addr_q;
    assign o_inst_data  = out_data_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        drop_d       = drop_q;
        skid_valid_d = skid_valid_q;
        skid_addr_d  = skid_addr_q;
        skid_data_d  = skid_data_q;
        out_valid_d  = out_valid_q;
        out_addr_d   = out_addr_q;
        out_data_d   = out_data_q;

        unique case (state_q)
            StReq: begin
                if (handshake) begin
                    req_addr_d = pc_q;
                    pc_d       = pc_q + XLEN'(4);
                    state_d    = StWait;
                end
            end
            StWait: begin
                // Any response completes the single outstanding request, dropped or not.
                if (imem.rsp_valid) begin
                    drop_d  = 1'b0;
                    state_d = StReq;
                end
            end
            default: state_d = StReq;
        endcase

        // Skid and a fresh response are mutually exclusive: requests stop while skid is full.
        if (consume) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_addr_d   = skid_addr_q;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (load_rsp) begin
                out_valid_d = 1'b1;
                out_addr_d  = req_addr_q;
                out_data_d  = imem.rsp_data;
            end else begin
                out_valid_d = 1'b0;
                out_addr_d  = '0;
                out_data_d  = INST_NOP;
            end
        end else if (load_rsp) begin
            if (!out_valid_q) begin
                out_valid_d = 1'b1;
                out_addr_d  = req_addr_q;
                out_data_d  = imem.rsp_data;
            end else begin
                skid_valid_d = 1'b1;
                skid_addr_d  = req_addr_q;
                skid_data_d  = imem.rsp_data;
            end
        end

        if (redirect_valid) begin
            pc_d         = {redirect_pc[XLEN-1:2], 2'b00};
            out_valid_d  = 1'b0;
            out_addr_d   = '0;
            out_data_d   = INST_NOP;
            skid_valid_d = 1'b0;
            // Drop whatever is (or is about to be) outstanding past this cycle.
            if (handshake || ((state_q == StWait) && !imem.rsp_valid)) begin
                drop_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StReq;
            pc_q         <= RESET_PC;
            req_addr_q   <= '0;
            drop_q       <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_addr_q  <= '0;
            skid_data_q  <= INST_NOP;
            out_valid_q  <= 1'b0;
            out_addr_q   <= '0;
            out_data_q   <= INST_NOP;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            drop_q       <= drop_d;
            skid_valid_q <= skid_valid_d;
            skid_addr_q  <= skid_addr_d;
            skid_data_q  <= skid_data_d;
            out_valid_q  <= out_valid_d;
            out_addr_q   <= out_addr_d;
            out_data_q   <= out_data_d;
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with a small latency-programmable instruction memory.
module tb_ifu_fetch;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        stall = 1'b0;
    logic        o_inst_valid;
    logic [31:0] o_inst_addr;
    logic [31:0] o_inst_data;

    int checks = 0;
    int errors = 0;
    int lat = 1;

    always #5 clk = ~clk;

    ifu_fetch_if #(.XLEN(32), .INST_LEN(32)) imem ();

    ifu_fetch #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem           (imem),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .o_inst_valid   (o_inst_valid),
        .o_inst_addr    (o_inst_addr),
        .o_inst_data    (o_inst_data)
    );

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    // Memory: response 'lat' cycles after the handshake cycle, updated on the falling edge.
    initial begin : responder
        logic        pend;
        int          cnt;
        logic [31:0] pend_addr;
        pend = 1'b0;
        cnt = 0;
        pend_addr = '0;
        imem.rsp_valid = 1'b0;
        imem.rsp_data = '0;
        forever begin
            @(negedge clk);
            imem.rsp_valid = 1'b0;
            if (pend) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    imem.rsp_valid = 1'b1;
                    imem.rsp_data = mem_data(pend_addr);
                    pend = 1'b0;
                end
            end
            if (imem.req_valid && imem.req_ready) begin
                pend = 1'b1;
                pend_addr = imem.req_addr;
                cnt = lat;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        imem.req_ready = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        repeat (n) step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        imem.req_ready = 1'b0;
        lat = 1;
        step();
        checks++;
        if (o_inst_valid !== 1'b0 || o_inst_addr !== 32'h0 || o_inst_data !== NOP) begin
            errors++;
            $display("FAIL reset_slot: got %b/%h/%h want 0/00000000/%h",
                     o_inst_valid, o_inst_addr, o_inst_data, NOP);
        end
        step();
        checks++;
        if (imem.req_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_req_valid: got %b want 0 while rst high", imem.req_valid);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (imem.req_valid !== 1'b1 || imem.req_addr !== RST_PC) begin
            errors++;
            $display("FAIL reset_first_req: got %b/%h want 1/%h",
                     imem.req_valid, imem.req_addr, RST_PC);
        end
    endtask

    task automatic test_basic();
        lat = 1;
        do_reset(4);
        for (int i = 0; i < 3; i++) begin
            logic [31:0] a;
            a = RST_PC + 32'(4 * i);
            checks++;
            if (imem.req_valid !== 1'b1 || imem.req_addr !== a) begin
                errors++;
                $display("FAIL basic_req[%0d]: got %b/%h want 1/%h",
                         i, imem.req_valid, imem.req_addr, a);
            end
            step();
            checks++;
            if (imem.req_valid !== 1'b0 || o_inst_valid !== 1'b0 || o_inst_data !== NOP) begin
                errors++;
                $display("FAIL basic_wait[%0d]: got req %b out %b/%h want 0 0/%h",
                         i, imem.req_valid, o_inst_valid, o_inst_data, NOP);
            end
            step();
            checks++;
            if (o_inst_valid !== 1'b1 || o_inst_addr !== a || o_inst_data !== mem_data(a)) begin
                errors++;
                $display("FAIL basic_out[%0d]: got %b/%h/%h want 1/%h/%h",
                         i, o_inst_valid, o_inst_addr, o_inst_data, a, mem_data(a));
            end
        end
    endtask

    task automatic test_stall();
        lat = 1;
        do_reset(4);
        step();
        step();
        stall = 1'b1;
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (o_inst_valid !== 1'b1 || o_inst_addr !== RST_PC ||
                o_inst_data !== mem_data(RST_PC)) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got %b/%h/%h want 1/%h/%h", k,
                         o_inst_valid, o_inst_addr, o_inst_data, RST_PC, mem_data(RST_PC));
            end
            if (k >= 1) begin
                checks++;
                if (imem.req_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_no_req[%0d]: got %b want 0", k, imem.req_valid);
                end
            end
            step();
        end
        stall = 1'b0;
        checks++;
        if (o_inst_valid !== 1'b1 || o_inst_addr !== RST_PC) begin
            errors++;
            $display("FAIL stall_release0: got %b/%h want 1/%h", o_inst_valid, o_inst_addr, RST_PC);
        end
        step();
        checks++;
        if (o_inst_valid !== 1'b1 || o_inst_addr !== RST_PC + 32'h4 ||
            o_inst_data !== mem_data(RST_PC + 32'h4)) begin
            errors++;
            $display("FAIL stall_release1: got %b/%h/%h want 1/%h/%h", o_inst_valid,
                     o_inst_addr, o_inst_data, RST_PC + 32'h4, mem_data(RST_PC + 32'h4));
        end
        checks++;
        if (imem.req_valid !== 1'b1 || imem.req_addr !== RST_PC + 32'h8) begin
            errors++;
            $display("FAIL stall_resume_req: got %b/%h want 1/%h",
                     imem.req_valid, imem.req_addr, RST_PC + 32'h8);
        end
        step();
        step();
        checks++;
        if (o_inst_valid !== 1'b1 || o_inst_addr !== RST_PC + 32'h8) begin
            errors++;
            $display("FAIL stall_resume_out: got %b/%h want 1/%h",
                     o_inst_valid, o_inst_addr, RST_PC + 32'h8);
        end
    endtask

    task automatic test_redirect_wait();
        lat = 3;
        do_reset(4);
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0103;
        step();
        redirect_valid = 1'b0;
        // Cycles 2..7: nothing stale may appear; request to target issued in cycle 4.
        for (int c = 2; c < 8; c++) begin
            checks++;
            if (o_inst_valid !== 1'b0 || o_inst_data !== NOP || o_inst_addr !== 32'h0) begin
                errors++;
                $display("FAIL redir_wait_out[%0d]: got %b/%h/%h want 0/00000000/%h",
                         c, o_inst_valid, o_inst_addr, o_inst_data, NOP);
            end
            if (c == 2 || c == 3) begin
                checks++;
                if (imem.req_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL redir_wait_noreq[%0d]: got %b want 0", c, imem.req_valid);
                end
            end
            if (c == 4) begin
                checks++;
                if (imem.req_valid !== 1'b1 || imem.req_addr !== 32'h8000_0100) begin
                    errors++;
                    $display("FAIL redir_wait_req: got %b/%h want 1/80000100",
                             imem.req_valid, imem.req_addr);
                end
            end
            step();
        end
        checks++;
        if (o_inst_valid !== 1'b1 || o_inst_addr !== 32'h8000_0100 ||
            o_inst_data !== mem_data(32'h8000_0100)) begin
            errors++;
            $display("FAIL redir_wait_target: got %b/%h/%h want 1/80000100/%h",
                     o_inst_valid, o_inst_addr, o_inst_data, mem_data(32'h8000_0100));
        end
    endtask

    task automatic test_redirect_handshake();
        lat = 1;
        do_reset(4);
        step();
        step();
        // Slot valid and stalled, request for +4 handshaking, redirect all in one cycle.
        stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0200;
        checks++;
        if (imem.req_valid !== 1'b1 || o_inst_valid !== 1'b1) begin
            errors++;
            $display("FAIL redir_hs_setup: got req %b out %b want 1 1",
                     imem.req_valid, o_inst_valid);
        end
        step();
        redirect_valid = 1'b0;
        stall = 1'b0;
        for (int c = 3; c < 6; c++) begin
            checks++;
            if (o_inst_valid !== 1'b0 || o_inst_data !== NOP || o_inst_addr !== 32'h0) begin
                errors++;
                $display("FAIL redir_hs_out[%0d]: got %b/%h/%h want 0/00000000/%h",
                         c, o_inst_valid, o_inst_addr, o_inst_data, NOP);
            end
            if (c == 4) begin
                checks++;
                if (imem.req_valid !== 1'b1 || imem.req_addr !== 32'h8000_0200) begin
                    errors++;
                    $display("FAIL redir_hs_req: got %b/%h want 1/80000200",
                             imem.req_valid, imem.req_addr);
                end
            end
            step();
        end
        checks++;
        if (o_inst_valid !== 1'b1 || o_inst_addr !== 32'h8000_0200 ||
            o_inst_data !== mem_data(32'h8000_0200)) begin
            errors++;
            $display("FAIL redir_hs_target: got %b/%h/%h want 1/80000200/%h",
                     o_inst_valid, o_inst_addr, o_inst_data, mem_data(32'h8000_0200));
        end
    endtask

    task automatic test_ready_low();
        lat = 1;
        do_reset(4);
        imem.req_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (imem.req_valid !== 1'b1 || imem.req_addr !== RST_PC) begin
                errors++;
                $display("FAIL ready_low_hold[%0d]: got %b/%h want 1/%h",
                         k, imem.req_valid, imem.req_addr, RST_PC);
            end
            step();
        end
        imem.req_ready = 1'b1;
        step();
        step();
        checks++;
        if (o_inst_valid !== 1'b1 || o_inst_addr !== RST_PC ||
            imem.req_addr !== RST_PC + 32'h4) begin
            errors++;
            $display("FAIL ready_low_after: got out %b/%h req %h want 1/%h req %h",
                     o_inst_valid, o_inst_addr, imem.req_addr, RST_PC, RST_PC + 32'h4);
        end
    endtask

    task automatic test_reset_mid();
        lat = 2;
        do_reset(4);
        step();
        step();
        step();
        stall = 1'b1;
        step();
        checks++;
        if (o_inst_valid !== 1'b1 || imem.req_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_setup: got out %b req %b want 1 0",
                     o_inst_valid, imem.req_valid);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        stall = 1'b0;
        #1;
        checks++;
        if (o_inst_valid !== 1'b0 || o_inst_data !== NOP || o_inst_addr !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_slot: got %b/%h/%h want 0/00000000/%h",
                     o_inst_valid, o_inst_addr, o_inst_data, NOP);
        end
        checks++;
        if (imem.req_valid !== 1'b1 || imem.req_addr !== RST_PC) begin
            errors++;
            $display("FAIL rst_mid_req: got %b/%h want 1/%h",
                     imem.req_valid, imem.req_addr, RST_PC);
        end
        step();
        for (int c = 6; c < 8; c++) begin
            checks++;
            if (o_inst_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_stale[%0d]: got valid %b addr %h want 0",
                         c, o_inst_valid, o_inst_addr);
            end
            step();
        end
        checks++;
        if (o_inst_valid !== 1'b1 || o_inst_addr !== RST_PC ||
            o_inst_data !== mem_data(RST_PC)) begin
            errors++;
            $display("FAIL rst_mid_restart: got %b/%h/%h want 1/%h/%h",
                     o_inst_valid, o_inst_addr, o_inst_data, RST_PC, mem_data(RST_PC));
        end
    endtask

    task automatic test_wrap();
        lat = 1;
        do_reset(4);
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        step();
        redirect_valid = 1'b0;
        step();
        checks++;
        if (imem.req_valid !== 1'b1 || imem.req_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_req_top: got %b/%h want 1/fffffffc",
                     imem.req_valid, imem.req_addr);
        end
        step();
        step();
        checks++;
        if (o_inst_valid !== 1'b1 || o_inst_addr !== 32'hFFFF_FFFC ||
            imem.req_addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_next: got out %b/%h req %h want 1/fffffffc req 00000000",
                     o_inst_valid, o_inst_addr, imem.req_addr);
        end
    endtask

    initial begin
        imem.req_ready = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_redirect_wait();
        test_redirect_handshake();
        test_ready_low();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
